// File: rtl/reg_file_8x16_reader.sv
// Eight-entry register file with CE-gated write, two registered read ports
// (write-through bypass) and a valid/ready sequencer that streams every entry in order.
module reg_file_8x16_reader #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] sin,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] qout_a,
    output logic [WIDTH-1:0] qout_b,
    input  logic             dump_go,
    output logic             dump_busy,
    output logic             dump_vld,
    input  logic             dump_rdy,
    output logic [AW-1:0]    dump_addr,
    output logic [WIDTH-1:0] dump_dat
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] qout_a_q, qout_a_d;
    logic [WIDTH-1:0] qout_b_q, qout_b_d;

    state_t           state_q;
    logic [AW-1:0]    idx_q;
    logic             dump_busy_q;
    logic             dump_vld_q;
    logic [AW-1:0]    dump_addr_q;
    logic [WIDTH-1:0] dump_dat_q;

    // mem_d is the post-write view, so every reader of it gets the write bypass for free
    always_comb begin
        mem_d = mem_q;
        if (ce) begin
            mem_d[waddr] = sin;
        end
        qout_a_d = mem_d[raddr_a];
        qout_b_d = mem_d[raddr_b];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            qout_a_q <= '0;
            qout_b_q <= '0;
        end else begin
            mem_q    <= mem_d;
            qout_a_q <= qout_a_d;
            qout_b_q <= qout_b_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            dump_busy_q <= 1'b0;
            dump_vld_q  <= 1'b0;
            dump_addr_q <= '0;
            dump_dat_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dump_go) begin
                        state_q     <= LOAD;
                        idx_q       <= '0;
                        dump_busy_q <= 1'b1;
                    end
                end
                LOAD: begin
                    dump_dat_q  <= mem_d[idx_q];
                    dump_addr_q <= idx_q;
                    dump_vld_q  <= 1'b1;
                    state_q     <= SEND;
                end
                SEND: begin
                    // Completion keys off the last index, not on idx wrapping back to zero
                    if (dump_rdy) begin
                        dump_vld_q <= 1'b0;
                        if (idx_q == AW'(DEPTH - 1)) begin
                            state_q     <= IDLE;
                            dump_busy_q <= 1'b0;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= LOAD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign qout_a    = qout_a_q;
    assign qout_b    = qout_b_q;
    assign dump_busy = dump_busy_q;
    assign dump_vld  = dump_vld_q;
    assign dump_addr = dump_addr_q;
    assign dump_dat  = dump_dat_q;

endmodule

// File: tb/tb_reg_file_8x16_reader.sv
// Bench for reg_file_8x16_reader: directed and random steps checked against an
// array model of the registers and a beat-level model of the dump stream.
module tb_reg_file_8x16_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [2:0]  waddr;
    logic [15:0] sin;
    logic [2:0]  raddr_a, raddr_b;
    logic [15:0] qout_a, qout_b;
    logic        dump_go, dump_busy, dump_vld, dump_rdy;
    logic [2:0]  dump_addr;
    logic [15:0] dump_dat;

    reg_file_8x16_reader #(.WIDTH(16), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .ce(ce), .waddr(waddr), .sin(sin),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .qout_a(qout_a), .qout_b(qout_b),
        .dump_go(dump_go), .dump_busy(dump_busy), .dump_vld(dump_vld),
        .dump_rdy(dump_rdy), .dump_addr(dump_addr), .dump_dat(dump_dat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_mem   [8];
    logic [15:0] rd_snap [8];
    logic        m_busy;
    int          beats;
    int          hold;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
        m_busy = 1'b0;
        beats  = 0;
    endtask

    // One clock with the currently driven inputs, then compare against the model.
    task automatic step();
        logic        pre_vld, hs, go_acc;
        logic [2:0]  pre_addr;
        logic [15:0] pre_dat, exp_a, exp_b;
        pre_vld  = dump_vld;
        pre_addr = dump_addr;
        pre_dat  = dump_dat;
        for (int i = 0; i < 8; i++)
            rd_snap[i] = (ce && waddr == 3'(i)) ? sin : m_mem[i];
        exp_a  = rd_snap[raddr_a];
        exp_b  = rd_snap[raddr_b];
        hs     = pre_vld && dump_rdy;
        go_acc = !m_busy && dump_go;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) m_mem[i] = rd_snap[i];
        if (go_acc) begin
            m_busy = 1'b1;
            beats  = 0;
        end
        if (hs) begin
            beats++;
            if (beats == 8) m_busy = 1'b0;
        end
        chk("qout_a", qout_a, exp_a);
        chk("qout_b", qout_b, exp_b);
        chk("dump_busy", 16'(dump_busy), 16'(m_busy));
        if (hs) begin
            chk("vld_after_accept", 16'(dump_vld), 16'h0000);
        end else if (pre_vld) begin
            chk("stall_vld", 16'(dump_vld), 16'h0001);
            chk("stall_addr", 16'(dump_addr), 16'(pre_addr));
            chk("stall_dat", dump_dat, pre_dat);
        end else if (dump_vld) begin
            chk("beat_addr", 16'(dump_addr), 16'(beats[2:0]));
            chk("beat_dat", dump_dat, rd_snap[dump_addr]);
        end
    endtask

    task automatic read_all();
        ce = 1'b0;
        for (int a = 0; a < 8; a++) begin
            raddr_a = 3'(a);
            raddr_b = 3'(7 - a);
            step();
        end
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; waddr = '0; sin = '0; raddr_a = '0; raddr_b = '0;
        dump_go = 1'b0; dump_rdy = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_qout_a", qout_a, 16'h0000);
        chk("rst_qout_b", qout_b, 16'h0000);
        chk("rst_busy", 16'(dump_busy), 16'h0000);
        chk("rst_vld", 16'(dump_vld), 16'h0000);
        chk("rst_addr", 16'(dump_addr), 16'h0000);
        chk("rst_dat", dump_dat, 16'h0000);
        rst = 1'b0;
        read_all();

        // Write then read, and ce=0 leaves storage alone
        ce = 1'b1; waddr = 3'd3; sin = 16'h0001; raddr_a = 3'd0;
        step();
        ce = 1'b0; sin = 16'h0000; raddr_a = 3'd3;
        step();
        chk("wr_rd_reg3", qout_a, 16'h0001);
        step();
        chk("ce0_hold_reg3", qout_a, 16'h0001);

        // Same-cycle write/read bypass on both ports
        ce = 1'b1; waddr = 3'd5; sin = 16'hA5A5; raddr_a = 3'd5; raddr_b = 3'd5;
        step();
        chk("bypass_a", qout_a, 16'hA5A5);
        chk("bypass_b", qout_b, 16'hA5A5);

        for (int n = 0; n < 40; n++) begin
            ce = 1'($urandom); waddr = 3'($urandom); sin = 16'($urandom);
            raddr_a = 3'($urandom); raddr_b = 3'($urandom);
            step();
        end

        // Full dump with downstream always ready
        for (int i = 0; i < 8; i++) begin
            ce = 1'b1; waddr = 3'(i); sin = 16'h0100 + 16'(i);
            step();
        end
        ce = 1'b0;
        dump_go = 1'b1;
        step();
        dump_go = 1'b0; dump_rdy = 1'b1;
        for (int c = 0; c < 100 && m_busy; c++) begin
            if (dump_vld) chk("dump1_dat", dump_dat, 16'h0100 + 16'(dump_addr));
            step();
        end
        chk("dump1_beats", 16'(beats), 16'd8);
        chk("dump1_busy_end", 16'(dump_busy), 16'h0000);

        // Stall beat 2 for 5 cycles and pulse dump_go while busy
        hold = 0;
        dump_go = 1'b1;
        step();
        dump_go = 1'b0;
        for (int c = 0; c < 100 && m_busy; c++) begin
            if (dump_vld && dump_addr == 3'd2 && hold < 5) begin
                dump_rdy = 1'b0;
                hold++;
                chk("stall2_dat", dump_dat, 16'h0102);
            end else begin
                dump_rdy = 1'b1;
            end
            dump_go = (c == 6);
            step();
        end
        dump_go = 1'b0;
        chk("stall2_cycles", 16'(hold), 16'd5);
        chk("dump2_beats", 16'(beats), 16'd8);

        // Random writes and random ready during a dump
        dump_go = 1'b1;
        step();
        dump_go = 1'b0;
        for (int c = 0; c < 200 && m_busy; c++) begin
            ce = 1'($urandom); waddr = 3'($urandom); sin = 16'($urandom);
            raddr_a = 3'($urandom); raddr_b = 3'($urandom);
            dump_rdy = 1'($urandom);
            step();
        end
        ce = 1'b0;
        chk("dump3_beats", 16'(beats), 16'd8);

        // Asynchronous reset while beat 4 is presented
        for (int i = 0; i < 8; i++) begin
            ce = 1'b1; waddr = 3'(i); sin = 16'hBEE0 + 16'(i); raddr_a = 3'(i); raddr_b = 3'(i);
            step();
        end
        ce = 1'b0; dump_rdy = 1'b1;
        dump_go = 1'b1;
        step();
        dump_go = 1'b0;
        for (int c = 0; c < 100 && !(dump_vld && dump_addr == 3'd4); c++) begin
            dump_rdy = 1'b1;
            step();
        end
        chk("reach_beat4", 16'(dump_addr), 16'h0004);
        dump_rdy = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_vld", 16'(dump_vld), 16'h0000);
        chk("arst_busy", 16'(dump_busy), 16'h0000);
        chk("arst_qout_a", qout_a, 16'h0000);
        chk("arst_qout_b", qout_b, 16'h0000);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        dump_rdy = 1'b1;
        read_all();
        chk("arst_no_beats", 16'(dump_vld), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
